sevenseg_scan_driver: RTL and testbench

SEVENSEG_SCAN_DRIVER -- requirements
Module: sevenseg_scan_driver

---
 rtl/sevenseg_scan_driver.sv | 167 ++++++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed hex seven-segment scan driver with frame-synchronous data update.
// Optional blink feature enabled by defining SEVENSEG_BLINK_EN.
module sevenseg_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]           pcnt;
  logic [IW-1:0]           idx;
  logic                    tc, boundary, wrapped;
  logic [4*NUM_DIGITS-1:0] shadow_val, pend_val;
  logic [NUM_DIGITS-1:0]   shadow_dp, pend_dp;
  logic                    pend;
  logic [NUM_DIGITS-1:0]   blink_mask;

  logic [6:0]            seg_n;
  logic                  dp_n;
  logic [NUM_DIGITS-1:0] an_n;
  logic [NUM_DIGITS-1:0] lz;
  logic [3:0]            sel_nib;
  logic                  sel_dp, sel_lz, sel_blink, run;

  assign tc       = (pcnt == PW'(PRESCALE - 1));
  assign boundary = tc && (idx == IW'(NUM_DIGITS - 1));

`ifdef SEVENSEG_BLINK_EN
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [NUM_DIGITS-1:0] shadow_blink, pend_blink;
  logic [FW-1:0]         fcnt;
  logic                  blink_phase;

  assign blink_mask = blink_phase ? shadow_blink : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_blink <= '0;
      pend_blink   <= '0;
      fcnt         <= '0;
      blink_phase  <= 1'b0;
    end else begin
      if (load) pend_blink <= blink_in;
      if (boundary) begin
        if (load)      shadow_blink <= blink_in;
        else if (pend) shadow_blink <= pend_blink;
        if (fcnt == FW'(BLINK_FRAMES - 1)) begin
          fcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^blink_in;
  assign blink_mask   = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt       <= '0;
      idx        <= '0;
      wrapped    <= 1'b0;
      frame      <= 1'b0;
      seg        <= '1;
      dp         <= 1'b1;
      an         <= '1;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend       <= 1'b0;
    end else begin
      pcnt <= tc ? '0 : pcnt + 1'b1;
      if (tc) idx <= boundary ? '0 : idx + 1'b1;
      // an moves to digit 0 one clock after the boundary, so frame is delayed to match
      wrapped <= boundary;
      frame   <= wrapped;
      seg     <= seg_n;
      dp      <= dp_n;
      an      <= an_n;
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
      end
      if (boundary) begin
        if (load) begin
          shadow_val <= value;
          shadow_dp  <= dp_in;
        end else if (pend) begin
          shadow_val <= pend_val;
          shadow_dp  <= pend_dp;
        end
        pend <= 1'b0;
      end else if (load) begin
        pend <= 1'b1;
      end
    end
  end

  always_comb begin
    sel_nib   = '0;
    sel_dp    = 1'b0;
    sel_lz    = 1'b0;
    sel_blink = 1'b0;
    an_n      = '1;
    lz        = '0;
    run       = 1'b1;
    // lz[k] is set when nibbles k..NUM_DIGITS-1 are all zero
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      run = run && (shadow_val[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
      lz[NUM_DIGITS-1-j] = run;
    end
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        sel_nib   = shadow_val[4*i +: 4];
        sel_dp    = shadow_dp[i];
        sel_lz    = lz[i];
        sel_blink = blink_mask[i];
        an_n[i]   = 1'b0;
      end
    end
    case (sel_nib)
      4'h0: seg_n = 7'b1000000;
      4'h1: seg_n = 7'b1111001;
      4'h2: seg_n = 7'b0100100;
      4'h3: seg_n = 7'b0110000;
      4'h4: seg_n = 7'b0011001;
      4'h5: seg_n = 7'b0010010;
      4'h6: seg_n = 7'b0000010;
      4'h7: seg_n = 7'b1111000;
      4'h8: seg_n = 7'b0000000;
      4'h9: seg_n = 7'b0010000;
      4'hA: seg_n = 7'b0001000;
      4'hB: seg_n = 7'b0000011;
      4'hC: seg_n = 7'b1000110;
      4'hD: seg_n = 7'b0100001;
      4'hE: seg_n = 7'b0000110;
      default: seg_n = 7'b0001110;
    endcase
    dp_n = ~sel_dp;
    if (blank_lz && (idx != '0) && sel_lz) seg_n = '1;
    if (sel_blink) begin
      seg_n = '1;
      dp_n  = 1'b1;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver (NUM_DIGITS=4, PRESCALE=4); covers the
// blink path when SEVENSEG_BLINK_EN is defined, otherwise checks blink_in is ignored.
module tb_sevenseg_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned PS = 4;
  localparam int unsigned BF = 2;
`ifdef SEVENSEG_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GB = 7'b0000011;
  localparam logic [6:0] GC = 7'b1000110;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] BL = 7'b1111111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   value = '0;
  logic [ND-1:0] dp_in = '0;
  logic          load = 1'b0;
  logic          blank_lz = 1'b0;
  logic [ND-1:0] blink_in = '0;
  logic [6:0]    seg;
  logic          dp;
  logic [ND-1:0] an;
  logic          frame;

  int n_chk  = 0;
  int n_fail = 0;

  sevenseg_scan_driver #(
    .NUM_DIGITS  (ND),
    .PRESCALE    (PS),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .value   (value),
    .dp_in   (dp_in),
    .load    (load),
    .blank_lz(blank_lz),
    .blink_in(blink_in),
    .seg     (seg),
    .dp      (dp),
    .an      (an),
    .frame   (frame)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic to_frame();
    int k;
    k = 0;
    tick(1);
    while (frame !== 1'b1 && k < 40) begin
      tick(1);
      k++;
    end
    chk("frame_sync", {31'b0, frame}, 32'd1);
  endtask

  // Starts on the frame-pulse cycle; ends on the cycle just before the next boundary edge.
  task automatic check_digits(input string tag, input logic [27:0] segs, input logic [3:0] dpn);
    logic [3:0] an_exp;
    for (int d = 0; d < 4; d++) begin
      an_exp = ~(4'b0001 << d);
      chk({tag, "_an"}, {28'b0, an}, {28'b0, an_exp});
      chk({tag, "_seg"}, {25'b0, seg}, {25'b0, segs[7*d +: 7]});
      chk({tag, "_dp"}, {31'b0, dp}, {31'b0, dpn[d]});
      if (d < 3) tick(4);
    end
    tick(2);
  endtask

  initial begin
    logic [6:0] s1;

    // reset with a coincident load that must be ignored
    rst = 1'b1; load = 1'b1; value = 16'hFFFF; dp_in = 4'hF;
    tick(3);
    load = 1'b0; dp_in = 4'h0;
    chk("rst_seg", {25'b0, seg}, {25'b0, BL});
    chk("rst_dp", {31'b0, dp}, 32'd1);
    chk("rst_an", {28'b0, an}, 32'hF);
    chk("rst_frame", {31'b0, frame}, 32'd0);

    rst = 1'b0;
    tick(1);
    chk("first_an", {28'b0, an}, 32'hE);
    chk("first_seg", {25'b0, seg}, {25'b0, G0});
    tick(3);
    chk("slot_end_an", {28'b0, an}, 32'hE);
    tick(1);
    chk("slot_next_an", {28'b0, an}, 32'hD);

    // mid-frame load must not appear before the boundary
    value = 16'h1A5F; dp_in = 4'b0100; load = 1'b1;
    tick(1);
    load = 1'b0; dp_in = 4'h0;
    tick(3);
    chk("no_early_an", {28'b0, an}, 32'hB);
    chk("no_early_seg", {25'b0, seg}, {25'b0, G0});
    to_frame();
    check_digits("hex", {G1, GA, G5, GF}, 4'b1011);

    // load exactly on the boundary edge, leading-zero blanking on
    value = 16'h0050; blank_lz = 1'b1; load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(1);
    chk("bnd_frame", {31'b0, frame}, 32'd1);
    check_digits("lz_on", {BL, BL, G5, G0}, 4'hF);

    blank_lz = 1'b0;
    to_frame();
    check_digits("lz_off", {G0, G0, G5, G0}, 4'hF);

    // two loads in one frame: only the second is shown
    to_frame();
    tick(4);
    value = 16'h8888; load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(3);
    value = 16'hCBA5; load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(3);
    chk("old_frame_an", {28'b0, an}, 32'h7);
    chk("old_frame_seg", {25'b0, seg}, {25'b0, G0});
    to_frame();
    check_digits("dbl_load", {GC, GB, GA, G5}, 4'hF);

    // reset mid-scan with a pending load
    to_frame();
    tick(4);
    value = 16'h8888; load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_seg", {25'b0, seg}, {25'b0, BL});
    chk("mid_rst_dp", {31'b0, dp}, 32'd1);
    chk("mid_rst_an", {28'b0, an}, 32'hF);
    chk("mid_rst_frame", {31'b0, frame}, 32'd0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_an", {28'b0, an}, 32'hE);
    chk("post_rst_seg", {25'b0, seg}, {25'b0, G0});
    to_frame();
    check_digits("post_rst", {G0, G0, G0, G0}, 4'hF);

    // blink on digit 1; frames counted from reset release
    rst = 1'b1;
    tick(1);
    rst = 1'b0; value = 16'h1A5F; blink_in = 4'b0010; load = 1'b1;
    tick(1);
    load = 1'b0; blink_in = 4'h0;
    for (int f = 1; f <= 5; f++) begin
      to_frame();
      s1 = (BLINK && (f == 2 || f == 3)) ? BL : G5;
      check_digits("blink", {G1, GA, s1, GF}, 4'hF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
